// File: rtl/pe_tile_param.sv
// Configurable CGRA tile: two connection boxes feed a small PE, and a switch box routes
// tracks among four sides. Configuration is memory-mapped per tile with one-cycle readback.
module pe_tile_param #(
    parameter int WIDTH      = 16,
    parameter int NUM_TRACKS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [15:0]                      tile_id,
    input  logic [31:0]                      config_addr,
    input  logic [31:0]                      config_data,
    input  logic                             config_we,
    input  logic                             config_re,
    output logic [31:0]                      read_data,
    output logic                             read_valid,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]    in_wires,
    output logic [4*NUM_TRACKS*WIDTH-1:0]    out_wires
);
    localparam int NT   = NUM_TRACKS;
    localparam int SELW = (2 * NT > 1) ? $clog2(2 * NT) : 1;
    localparam int NW   = 4 * NT * WIDTH;

    localparam logic [7:0] FEAT_CB0 = 8'd0;
    localparam logic [7:0] FEAT_CB1 = 8'd1;
    localparam logic [7:0] FEAT_SB  = 8'd2;
    localparam logic [7:0] FEAT_PE  = 8'd3;
    localparam logic [2:0] OP_ACC   = 3'd6;

    logic [SELW-1:0]  cb0_q, cb0_d, cb1_q, cb1_d;
    logic [2*NT-1:0]  sb_sel_q [4];
    logic [2*NT-1:0]  sb_sel_d [4];
    logic [NT-1:0]    sb_en_q [4];
    logic [NT-1:0]    sb_en_d [4];
    logic [2:0]       pe_op_q, pe_op_d;
    logic             pe_en_q, pe_en_d;
    logic [WIDTH-1:0] acc_q, acc_d, pe_res_q, pe_res_d;
    logic [NW-1:0]    sb_out_q, sb_out_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;

    logic             matched;
    logic [7:0]       feat, idx;
    logic             rd_hit;
    logic [31:0]      rd_val;
    logic [WIDTH-1:0] op0, op1, alu, pe_out, pe_fb;
    logic [NT*WIDTH-1:0] sb0_fb;
    logic             unused_cfg;

    assign unused_cfg = &{1'b0, config_data};
    assign matched    = (config_addr[31:16] == tile_id);
    assign feat       = config_addr[15:8];
    assign idx        = config_addr[7:0];
    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

    function automatic logic [WIDTH-1:0] in_trk(input int s, input int t);
        return in_wires[(s*NT+t)*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] sb_src(input int s, input int t, input logic [1:0] sel,
                                                input logic [WIDTH-1:0] pe_v);
        case (sel)
            2'd0:    return in_trk((s + 2) % 4, t);
            2'd1:    return in_trk((s + 1) % 4, t);
            2'd2:    return in_trk((s + 3) % 4, t);
            default: return pe_v;
        endcase
    endfunction

    // Connection boxes tap side-0 outputs through a copy of the switch box in which the PE
    // term is its registered result, so PE -> SB -> CB -> PE never forms a combinational loop.
    assign pe_fb = (pe_op_q == OP_ACC) ? acc_q : pe_res_q;

    always_comb begin
        sb0_fb = '0;
        for (int t = 0; t < NT; t++) begin
            if (sb_en_q[0][t])
                sb0_fb[t*WIDTH +: WIDTH] = sb_out_q[t*WIDTH +: WIDTH];
            else
                sb0_fb[t*WIDTH +: WIDTH] = sb_src(0, t, sb_sel_q[0][2*t +: 2], pe_fb);
        end
    end

    function automatic logic [WIDTH-1:0] cb_pick(input logic [SELW-1:0] v);
        int k;
        k = int'(v);
        if (k < NT)
            return in_trk(0, k);
        else if (k - NT < NT)
            return sb0_fb[(k-NT)*WIDTH +: WIDTH];
        else
            return '0;
    endfunction

    always_comb begin
        op0 = cb_pick(cb0_q);
        op1 = cb_pick(cb1_q);
        case (pe_op_q)
            3'd0:    alu = op0 + op1;
            3'd1:    alu = op0 - op1;
            3'd2:    alu = op0 & op1;
            3'd3:    alu = op0 | op1;
            3'd4:    alu = op0 ^ op1;
            3'd5:    alu = op0;
            3'd6:    alu = acc_q;
            default: alu = '0;
        endcase
        pe_res_d = alu;
        if (pe_op_q == OP_ACC)
            pe_out = acc_q;
        else if (pe_en_q)
            pe_out = pe_res_q;
        else
            pe_out = alu;
    end

    always_comb begin
        sb_out_d  = '0;
        out_wires = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NT; t++) begin
                sb_out_d[(s*NT+t)*WIDTH +: WIDTH] = sb_src(s, t, sb_sel_q[s][2*t +: 2], pe_out);
                if (sb_en_q[s][t])
                    out_wires[(s*NT+t)*WIDTH +: WIDTH] = sb_out_q[(s*NT+t)*WIDTH +: WIDTH];
                else
                    out_wires[(s*NT+t)*WIDTH +: WIDTH] = sb_out_d[(s*NT+t)*WIDTH +: WIDTH];
            end
        end
    end

    // Configuration writes, accumulator and readback; reads see pre-write register values.
    always_comb begin
        cb0_d    = cb0_q;
        cb1_d    = cb1_q;
        sb_sel_d = sb_sel_q;
        sb_en_d  = sb_en_q;
        pe_op_d  = pe_op_q;
        pe_en_d  = pe_en_q;
        acc_d    = (pe_op_q == OP_ACC) ? acc_q + op0 : acc_q;
        rd_hit   = 1'b0;
        rd_val   = '0;

        if (config_we && matched) begin
            case (feat)
                FEAT_CB0: if (idx == 8'd0) cb0_d = config_data[SELW-1:0];
                FEAT_CB1: if (idx == 8'd0) cb1_d = config_data[SELW-1:0];
                FEAT_SB: if (idx < 8'd4) begin
                    sb_sel_d[idx[1:0]] = config_data[2*NT-1:0];
                    sb_en_d[idx[1:0]]  = config_data[16 +: NT];
                end
                FEAT_PE: if (idx == 8'd0) begin
                    pe_op_d = config_data[2:0];
                    pe_en_d = config_data[3];
                    acc_d   = '0;
                end
                default: ;
            endcase
        end

        if (config_re && matched) begin
            case (feat)
                FEAT_CB0: if (idx == 8'd0) begin rd_hit = 1'b1; rd_val[SELW-1:0] = cb0_q; end
                FEAT_CB1: if (idx == 8'd0) begin rd_hit = 1'b1; rd_val[SELW-1:0] = cb1_q; end
                FEAT_SB: if (idx < 8'd4) begin
                    rd_hit               = 1'b1;
                    rd_val[2*NT-1:0]     = sb_sel_q[idx[1:0]];
                    rd_val[16 +: NT]     = sb_en_q[idx[1:0]];
                end
                FEAT_PE: if (idx == 8'd0) begin rd_hit = 1'b1; rd_val[3:0] = {pe_en_q, pe_op_q}; end
                default: ;
            endcase
        end
        read_data_d  = rd_hit ? rd_val : read_data_q;
        read_valid_d = rd_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cb0_q        <= '0;
            cb1_q        <= '0;
            for (int s = 0; s < 4; s++) begin
                sb_sel_q[s] <= '0;
                sb_en_q[s]  <= '0;
            end
            pe_op_q      <= '0;
            pe_en_q      <= 1'b0;
            acc_q        <= '0;
            pe_res_q     <= '0;
            sb_out_q     <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            cb0_q        <= cb0_d;
            cb1_q        <= cb1_d;
            sb_sel_q     <= sb_sel_d;
            sb_en_q      <= sb_en_d;
            pe_op_q      <= pe_op_d;
            pe_en_q      <= pe_en_d;
            acc_q        <= acc_d;
            pe_res_q     <= pe_res_d;
            sb_out_q     <= sb_out_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end
endmodule

// File: tb/tb_pe_tile_param.sv
// Directed bench for pe_tile_param at default parameters (WIDTH=16, NUM_TRACKS=4).
module tb_pe_tile_param;
    localparam logic [15:0] TILE = 16'h00A5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   tile_id = TILE;
    logic [31:0]   config_addr = '0;
    logic [31:0]   config_data = '0;
    logic          config_we = 1'b0;
    logic          config_re = 1'b0;
    logic [31:0]   read_data;
    logic          read_valid;
    logic [255:0]  in_wires = '0;
    logic [255:0]  out_wires;

    int checks = 0;
    int failures = 0;

    pe_tile_param dut (
        .clk(clk), .reset(reset), .tile_id(tile_id),
        .config_addr(config_addr), .config_data(config_data),
        .config_we(config_we), .config_re(config_re),
        .read_data(read_data), .read_valid(read_valid),
        .in_wires(in_wires), .out_wires(out_wires)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int s, input int t, input logic [15:0] v);
        in_wires[(s*4+t)*16 +: 16] = v;
    endtask

    function automatic logic [15:0] get_out(input int s, input int t);
        return out_wires[(s*4+t)*16 +: 16];
    endfunction

    task automatic cfg_wr(input logic [7:0] f, input logic [7:0] i, input logic [31:0] d);
        config_addr = {TILE, f, i};
        config_data = d;
        config_we   = 1'b1;
        tick();
        config_we   = 1'b0;
    endtask

    task automatic cfg_rd(input logic [15:0] tid, input logic [7:0] f, input logic [7:0] i);
        config_addr = {tid, f, i};
        config_re   = 1'b1;
        tick();
        config_re   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        config_addr = {TILE, 8'd3, 8'd0};
        config_data = 32'h7;
        config_we = 1'b1;
        config_re = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        config_we = 1'b0;
        config_re = 1'b0;
        checks++;
        if (read_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b exp 0", read_valid); end
        checks++;
        if (read_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", read_data); end
        cfg_rd(TILE, 8'd3, 8'd0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h0) begin
            failures++; $display("FAIL reset_pe_reg got v=%0b d=%h exp v=1 d=0", read_valid, read_data);
        end
    endtask

    task automatic test_straight();
        set_in(2, 1, 16'h1234);
        set_in(1, 3, 16'hBEEF);
        #1;
        checks++;
        if (get_out(0, 1) !== 16'h1234) begin failures++; $display("FAIL straight_s0t1 got %h exp 1234", get_out(0, 1)); end
        checks++;
        if (get_out(3, 3) !== 16'hBEEF) begin failures++; $display("FAIL straight_s3t3 got %h exp beef", get_out(3, 3)); end
    endtask

    task automatic test_pe_ops();
        logic [2:0]  ops [6];
        logic [15:0] exps [6];
        ops  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        exps = '{16'h0E10, 16'h000F, 16'h0FFF, 16'h0FF0, 16'h0F0F, 16'h0000};
        cfg_wr(8'd0, 8'd0, 32'd1);
        cfg_wr(8'd1, 8'd0, 32'd2);
        cfg_wr(8'd3, 8'd0, 32'd0);
        cfg_wr(8'd2, 8'd1, 32'd3);
        set_in(0, 1, 16'd5);
        set_in(0, 2, 16'd7);
        #1;
        checks++;
        if (get_out(1, 0) !== 16'd12) begin failures++; $display("FAIL pe_add got %h exp 000c", get_out(1, 0)); end
        set_in(0, 1, 16'h0F0F);
        set_in(0, 2, 16'h00FF);
        for (int k = 0; k < 6; k++) begin
            cfg_wr(8'd3, 8'd0, {29'd0, ops[k]});
            checks++;
            if (get_out(1, 0) !== exps[k]) begin
                failures++; $display("FAIL pe_op%0d got %h exp %h", ops[k], get_out(1, 0), exps[k]);
            end
        end
        set_in(0, 1, 16'd2);
        set_in(0, 2, 16'd3);
        cfg_wr(8'd3, 8'd0, 32'd1);
        checks++;
        if (get_out(1, 0) !== 16'hFFFF) begin failures++; $display("FAIL pe_sub_wrap got %h exp ffff", get_out(1, 0)); end
        set_in(0, 1, 16'd10);
        set_in(0, 2, 16'd20);
        cfg_wr(8'd3, 8'd0, 32'h8);
        tick();
        checks++;
        if (get_out(1, 0) !== 16'd30) begin failures++; $display("FAIL pe_reg_val got %h exp 001e", get_out(1, 0)); end
        set_in(0, 1, 16'd11);
        #1;
        checks++;
        if (get_out(1, 0) !== 16'd30) begin failures++; $display("FAIL pe_reg_hold got %h exp 001e", get_out(1, 0)); end
        tick();
        checks++;
        if (get_out(1, 0) !== 16'd31) begin failures++; $display("FAIL pe_reg_next got %h exp 001f", get_out(1, 0)); end
    endtask

    task automatic test_accum();
        set_in(0, 1, 16'd3);
        set_in(3, 0, 16'h0777);
        cfg_wr(8'd3, 8'd0, 32'd6);
        checks++;
        if (get_out(1, 0) !== 16'd0) begin failures++; $display("FAIL acc_start got %h exp 0", get_out(1, 0)); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (get_out(1, 0) !== 16'(3 * k)) begin
                failures++; $display("FAIL acc_step%0d got %h exp %h", k, get_out(1, 0), 16'(3 * k));
            end
        end
        cfg_wr(8'd3, 8'd0, 32'd6);
        checks++;
        if (get_out(1, 0) !== 16'd0) begin failures++; $display("FAIL acc_rewrite got %h exp 0", get_out(1, 0)); end
        tick();
        tick();
        checks++;
        if (get_out(1, 0) !== 16'd6) begin failures++; $display("FAIL acc_resume got %h exp 0006", get_out(1, 0)); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (get_out(1, 0) !== 16'h0777) begin failures++; $display("FAIL acc_reset_route got %h exp 0777", get_out(1, 0)); end
        cfg_wr(8'd0, 8'd0, 32'd1);
        cfg_wr(8'd2, 8'd1, 32'd3);
        checks++;
        if (get_out(1, 0) !== 16'd3) begin failures++; $display("FAIL acc_reset_add got %h exp 0003", get_out(1, 0)); end
        cfg_wr(8'd3, 8'd0, 32'd6);
        tick();
        checks++;
        if (get_out(1, 0) !== 16'd3) begin failures++; $display("FAIL acc_after_reset got %h exp 0003", get_out(1, 0)); end
    endtask

    task automatic test_unmatched();
        config_addr = {TILE ^ 16'h1, 8'd3, 8'd0};
        config_data = 32'h5;
        config_we = 1'b1;
        tick();
        config_we = 1'b0;
        cfg_rd(TILE, 8'd3, 8'd0);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h6) begin
            failures++; $display("FAIL unmatched_wr got v=%0b d=%h exp v=1 d=6", read_valid, read_data);
        end
        cfg_rd(TILE ^ 16'h1, 8'd3, 8'd0);
        checks++;
        if (read_valid !== 1'b0 || read_data !== 32'h6) begin
            failures++; $display("FAIL unmatched_rd got v=%0b d=%h exp v=0 d=6", read_valid, read_data);
        end
        cfg_rd(TILE, 8'd4, 8'd0);
        checks++;
        if (read_valid !== 1'b0 || read_data !== 32'h6) begin
            failures++; $display("FAIL undef_rd got v=%0b d=%h exp v=0 d=6", read_valid, read_data);
        end
    endtask

    task automatic test_rw_same();
        config_addr = {TILE, 8'd2, 8'd2};
        config_data = 32'h5;
        config_we = 1'b1;
        config_re = 1'b1;
        tick();
        config_we = 1'b0;
        config_re = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h0) begin
            failures++; $display("FAIL rw_old got v=%0b d=%h exp v=1 d=0", read_valid, read_data);
        end
        tick();
        checks++;
        if (read_valid !== 1'b0) begin failures++; $display("FAIL rw_pulse got %0b exp 0", read_valid); end
        cfg_rd(TILE, 8'd2, 8'd2);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 32'h5) begin
            failures++; $display("FAIL rw_new got v=%0b d=%h exp v=1 d=5", read_valid, read_data);
        end
    endtask

    task automatic test_sb_reg();
        set_in(2, 0, 16'hAAAA);
        cfg_wr(8'd2, 8'd0, 32'h0001_0000);
        checks++;
        if (get_out(0, 0) !== 16'hAAAA) begin failures++; $display("FAIL sbreg_first got %h exp aaaa", get_out(0, 0)); end
        set_in(2, 0, 16'h5555);
        #1;
        checks++;
        if (get_out(0, 0) !== 16'hAAAA) begin failures++; $display("FAIL sbreg_hold got %h exp aaaa", get_out(0, 0)); end
        tick();
        checks++;
        if (get_out(0, 0) !== 16'h5555) begin failures++; $display("FAIL sbreg_lag got %h exp 5555", get_out(0, 0)); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_pe_ops();
        test_accum();
        test_unmatched();
        test_rw_same();
        test_sb_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
